// File: rtl/axis_frame_source.sv
// axis_frame_source: AXI-Stream master that replays frames of signed samples
// from a small host-loaded buffer. The host writes samples while idle, pulses
// start, and the block emits frame_len beats per frame, num_frames times, with
// tlast on the last beat of each frame. All outputs are registered.
//
// Optional feature: define AXIS_FRAME_SOURCE_GAP_EN to insert gap_len idle
// cycles (tvalid low) between frames. Without it gap_len is ignored and frames
// are always back-to-back.
module axis_frame_source #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int LEN_WIDTH  = $clog2(DEPTH) + 1,
    parameter int GAP_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  frame_len,
    input  logic [7:0]            num_frames,
    input  logic [GAP_WIDTH-1:0]  gap_len,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] sample_mem [DEPTH];
    logic [ADDR_WIDTH:0]   idx;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [7:0]            frames_left;

    logic                  wr_accept;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic [DATA_WIDTH-1:0] first_data;

`ifdef AXIS_FRAME_SOURCE_GAP_EN
    logic [GAP_WIDTH-1:0]  gap_len_q;
    logic [GAP_WIDTH-1:0]  gap_cnt;
`else
    logic                  unused_gap;
    assign unused_gap = ^gap_len;
`endif

    // Write qualification, length clamp and beat-0 bypass of a same-cycle write.
    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_accept   = 1'b0;
        len_clamped = frame_len;
        first_data  = sample_mem[0];
        wr_accept   = wr_en && (state == IDLE) && !busy;
        if (frame_len > LEN_WIDTH'(DEPTH))
            len_clamped = LEN_WIDTH'(DEPTH);
        if (wr_accept && (wr_addr == '0))
            first_data = wr_data;
    end

    // Sample buffer: host writes land only while idle.
    // NOTE: the buffer has no reset; its contents are only meaningful after the
    // host loads them, and leaving it unreset lets it map onto plain storage.
    always_ff @(posedge clk) begin
        if (wr_accept)
            sample_mem[wr_addr] <= wr_data;
    end

    // Control FSM and registered output stage.
    // NOTE: all sequential state uses non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            idx           <= '0;
            len_q         <= '0;
            frames_left   <= '0;
`ifdef AXIS_FRAME_SOURCE_GAP_EN
            gap_len_q     <= '0;
            gap_cnt       <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (frame_len != '0)) begin
                        state         <= STREAM;
                        busy          <= 1'b1;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= first_data;
                        m_axis_tlast  <= (len_clamped == LEN_WIDTH'(1));
                        idx           <= (ADDR_WIDTH+1)'(1);
                        len_q         <= len_clamped;
                        frames_left   <= (num_frames == 8'd0) ? 8'd1 : num_frames;
`ifdef AXIS_FRAME_SOURCE_GAP_EN
                        gap_len_q     <= gap_len;
`endif
                    end
                end
                STREAM: begin
                    if (m_axis_tvalid && m_axis_tready) begin
                        if (m_axis_tlast) begin
                            if (frames_left > 8'd1) begin
                                frames_left <= frames_left - 8'd1;
`ifdef AXIS_FRAME_SOURCE_GAP_EN
                                if (gap_len_q != '0) begin
                                    state         <= GAP;
                                    m_axis_tvalid <= 1'b0;
                                    m_axis_tlast  <= 1'b0;
                                    gap_cnt       <= gap_len_q;
                                end else begin
                                    m_axis_tdata <= sample_mem[0];
                                    m_axis_tlast <= (len_q == LEN_WIDTH'(1));
                                    idx          <= (ADDR_WIDTH+1)'(1);
                                end
`else
                                m_axis_tdata <= sample_mem[0];
                                m_axis_tlast <= (len_q == LEN_WIDTH'(1));
                                idx          <= (ADDR_WIDTH+1)'(1);
`endif
                            end else begin
                                state         <= IDLE;
                                busy          <= 1'b0;
                                done          <= 1'b1;
                                m_axis_tvalid <= 1'b0;
                                m_axis_tlast  <= 1'b0;
                            end
                        end else begin
                            m_axis_tdata <= sample_mem[idx[ADDR_WIDTH-1:0]];
                            m_axis_tlast <= (idx == (len_q - LEN_WIDTH'(1)));
                            idx          <= idx + (ADDR_WIDTH+1)'(1);
                        end
                    end
                end
`ifdef AXIS_FRAME_SOURCE_GAP_EN
                GAP: begin
                    if (gap_cnt == GAP_WIDTH'(1)) begin
                        state         <= STREAM;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= sample_mem[0];
                        m_axis_tlast  <= (len_q == LEN_WIDTH'(1));
                        idx           <= (ADDR_WIDTH+1)'(1);
                    end else begin
                        gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_frame_source.sv
// Self-checking bench for axis_frame_source. Expected beats are pushed to a
// scoreboard queue when a run is started and popped by a monitor on each
// handshake; run timing, busy and done are checked around every run.
module tb_axis_frame_source;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LW    = 5;
    localparam int GW    = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [LW-1:0] frame_len;
    logic [7:0]    num_frames;
    logic [GW-1:0] gap_len;
    logic          busy;
    logic          done;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t                 exp_q [$];
    logic signed [DW-1:0]  model_buf [DEPTH];
    int                    tests = 0;
    int                    fails = 0;

    always #5 clk = ~clk;

    axis_frame_source #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .GAP_WIDTH(GW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .frame_len(frame_len), .num_frames(num_frames), .gap_len(gap_len),
        .busy(busy), .done(done),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each handshake, and check stalled beats stay put.
    always @(negedge clk) begin
        if (rst_n && m_axis_tvalid) begin
            check("beat_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                if (m_axis_tready) begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check("tdata", $signed(m_axis_tdata), $signed(b.data));
                    check("tlast", m_axis_tlast, b.last);
                end else begin
                    check("stall_tdata", $signed(m_axis_tdata), $signed(exp_q[0].data));
                    check("stall_tlast", m_axis_tlast, exp_q[0].last);
                end
            end
        end
    end

    task automatic write_buf(input int addr, input logic signed [DW-1:0] val);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = val;
        model_buf[addr] = val;
        tick();
        wr_en = 1'b0;
    endtask

    // One run: tready low for relative cycles st_lo..st_hi (c=0 is the first beat
    // cycle); optional ignored write while busy; optional write to buf[0] with start.
    task automatic run(input int len, input int nf, input int gap,
                       input int st_lo, input int st_hi,
                       input bit busy_wr, input bit wr0_with_start,
                       input logic signed [DW-1:0] wr0_val);
        int eff_len;
        int eff_nf;
        int c;
        int exp_c;
        eff_len = (len > DEPTH) ? DEPTH : len;
        eff_nf  = (nf == 0) ? 1 : nf;
        c       = 0;
        if (wr0_with_start) begin
            wr_en        = 1'b1;
            wr_addr      = '0;
            wr_data      = wr0_val;
            model_buf[0] = wr0_val;
        end
        frame_len  = LW'(len);
        num_frames = 8'(nf);
        gap_len    = GW'(gap);
        start      = 1'b1;
        for (int f = 0; f < eff_nf; f++)
            for (int k = 0; k < eff_len; k++)
                exp_q.push_back(beat_t'{data: model_buf[k], last: (k == eff_len - 1)});
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        check("busy_after_start", busy, 1);
        check("tvalid_after_start", m_axis_tvalid, 1);
        check("tdata_beat0", $signed(m_axis_tdata), model_buf[0]);
        while (!done && c < 500) begin
            m_axis_tready = !(c >= st_lo && c <= st_hi);
            if (busy_wr && c == 1) begin
                wr_en   = 1'b1;
                wr_addr = AW'(1);
                wr_data = 8'd99;
            end else begin
                wr_en = 1'b0;
            end
            tick();
            c++;
            if (!done) check("busy_during_run", busy, 1);
        end
        wr_en         = 1'b0;
        m_axis_tready = 1'b1;
        exp_c = eff_len * eff_nf + ((st_hi >= st_lo) ? (st_hi - st_lo + 1) : 0);
`ifdef AXIS_FRAME_SOURCE_GAP_EN
        exp_c += (eff_nf - 1) * gap;
`endif
        check("done_cycle", c, exp_c);
        check("busy_at_done", busy, 0);
        check("queue_empty", exp_q.size(), 0);
        exp_q.delete();
        tick();
        check("done_one_cycle", done, 0);
        check("tvalid_after_run", m_axis_tvalid, 0);
    endtask

    initial begin
        rst_n         = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = '0;
        wr_data       = '0;
        start         = 1'b0;
        frame_len     = '0;
        num_frames    = '0;
        gap_len       = '0;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        rst_n = 1'b1;
        tick();

        write_buf(0, 8'sd1);
        write_buf(1, -8'sd2);
        write_buf(2, 8'sd3);
        write_buf(3, -8'sd4);
        for (int i = 4; i < DEPTH; i++) write_buf(i, 8'(10 + i));

        // Basic frame, then with a three-cycle stall on beat 2.
        run(4, 1, 0, 1, 0, 1'b0, 1'b0, 8'sd0);
        run(4, 1, 0, 1, 3, 1'b0, 1'b0, 8'sd0);
        // Two back-to-back frames of three.
        run(3, 2, 0, 1, 0, 1'b0, 1'b0, 8'sd0);

        // frame_len == 0 is ignored.
        frame_len  = '0;
        num_frames = 8'd1;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("len0_busy", busy, 0);
            check("len0_tvalid", m_axis_tvalid, 0);
            check("len0_done", done, 0);
            tick();
        end

        // Clamp, num_frames==0, frame_len==1, stall across frames.
        run(20, 1, 0, 1, 0, 1'b0, 1'b0, 8'sd0);
        run(2, 0, 0, 1, 0, 1'b0, 1'b0, 8'sd0);
        run(1, 3, 0, 1, 2, 1'b0, 1'b0, 8'sd0);

        // Write while busy is ignored; the next run still sees buf[1] == -2.
        run(4, 1, 0, 1, 0, 1'b1, 1'b0, 8'sd0);
        run(4, 1, 0, 1, 0, 1'b0, 1'b0, 8'sd0);

        // Write to buf[0] in the start cycle is seen by beat 0.
        run(4, 2, 0, 1, 0, 1'b0, 1'b1, 8'sd7);
        write_buf(0, 8'sd1);

        // Reset asserted for one cycle while beat 2 is on the bus.
        frame_len  = LW'(4);
        num_frames = 8'd1;
        start      = 1'b1;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(beat_t'{data: model_buf[k], last: (k == 3)});
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_tvalid", m_axis_tvalid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        exp_q.delete();
        tick();
        check("midrst_no_done", done, 0);
        run(4, 1, 0, 1, 0, 1'b0, 1'b0, 8'sd0);

        // Inter-frame gap (contiguous in the default build) and gap_len == 0.
        run(2, 3, 2, 1, 0, 1'b0, 1'b0, 8'sd0);
        run(2, 3, 0, 1, 0, 1'b0, 1'b0, 8'sd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish by %0t", $time);
        $fatal(1);
    end

endmodule
